driver_array_core: RTL and testbench

Parametrised multi-channel successor to the single-channel dot driver core. It holds per-channel firing patterns (drive polarity and fire-enable words) and steps through them with a shared pattern index. It drives NUM_CHANNELS H-bridge p/n output pairs and inserts programmable dead time on every exit from a driving state. It sits after the synchronisers, in the core clock domain, directly in front of the H-bridge pads.

---
 rtl/driver_array_core.sv | 147 ++++++++++++++
 tb/tb_driver_array_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_array_core.sv
// Multi-channel H-bridge dot driver: per-channel polarity/enable pattern words stepped by a
// shared index, with a dead-time interval inserted whenever a channel leaves its driving state.
module driver_array_core #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_ADDR_W    = 2,
  parameter int PATTERN_LEN  = 16,
  parameter int IDX_W        = 4,
  parameter int DEADTIME     = 3,
  parameter int DT_W         = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_write,
  input  logic                      cfg_sel,
  input  logic [CH_ADDR_W-1:0]      cfg_channel,
  input  logic [PATTERN_LEN-1:0]    cfg_data,
  input  logic                      run,
  input  logic                      step,
  input  logic                      step_clear,
  input  logic                      output_active,
  input  logic [NUM_CHANNELS-1:0]   invert,
  output logic [IDX_W-1:0]          step_index,
  output logic                      cycle_done,
  output logic [2*NUM_CHANNELS-1:0] driver_io,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD} ch_state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PATTERN_LEN - 1);
  localparam logic [DT_W-1:0]  DEAD_LOAD = DT_W'(DEADTIME - 1);

  logic [PATTERN_LEN-1:0] state_word  [NUM_CHANNELS];
  logic [PATTERN_LEN-1:0] enable_word [NUM_CHANNELS];
  logic [IDX_W-1:0]       index_q;
  logic                   done_q;
  ch_state_t              ch_state [NUM_CHANNELS];
  logic                   ch_pol   [NUM_CHANNELS];
  logic [DT_W-1:0]        ch_cnt   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] req_on;
  logic [NUM_CHANNELS-1:0] req_pol;
  logic [NUM_CHANNELS-1:0] dead_vec;

  // Channel numbers with no matching loop iteration simply never get written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_word[c]  <= '0;
        enable_word[c] <= '0;
      end
    end else if (cfg_write) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (cfg_channel == CH_ADDR_W'(c)) begin
          if (cfg_sel) enable_word[c] <= cfg_data;
          else         state_word[c]  <= cfg_data;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index_q <= '0;
      done_q  <= 1'b0;
    end else if (step_clear) begin
      index_q <= '0;
      done_q  <= 1'b0;
    end else if (step && run) begin
      if (index_q == LAST_IDX) begin
        index_q <= '0;
        done_q  <= 1'b1;
      end else begin
        index_q <= index_q + 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  always_comb begin
    req_on  = '0;
    req_pol = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      req_on[c]  = output_active & enable_word[c][index_q];
      req_pol[c] = state_word[c][index_q] ^ invert[c];
    end
  end

  // The request is only consulted on the DEAD exit cycle, so mid-dead changes cannot restart it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        ch_state[c] <= IDLE;
        ch_pol[c]   <= 1'b0;
        ch_cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (ch_state[c])
          IDLE: begin
            if (req_on[c]) begin
              ch_state[c] <= DRIVE;
              ch_pol[c]   <= req_pol[c];
            end
          end
          DRIVE: begin
            if (!req_on[c] || (req_pol[c] != ch_pol[c])) begin
              ch_state[c] <= DEAD;
              ch_cnt[c]   <= DEAD_LOAD;
            end
          end
          DEAD: begin
            if (ch_cnt[c] == '0) begin
              if (req_on[c]) begin
                ch_state[c] <= DRIVE;
                ch_pol[c]   <= req_pol[c];
              end else begin
                ch_state[c] <= IDLE;
              end
            end else begin
              ch_cnt[c] <= ch_cnt[c] - 1'b1;
            end
          end
          default: ch_state[c] <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    driver_io = '0;
    dead_vec  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_state[c] == DRIVE) begin
        driver_io[2*c+1] = ch_pol[c];
        driver_io[2*c]   = ~ch_pol[c];
      end
      dead_vec[c] = (ch_state[c] == DEAD);
    end
  end

  assign busy       = |dead_vec;
  assign step_index = index_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_driver_array_core.sv
// Directed self-checking bench for driver_array_core: pattern drive, dead time, index wrap,
// out-of-range config on a 3-channel instance, and asynchronous reset during dead time.
module tb_driver_array_core;

  logic        clock;
  logic        reset;
  logic        cfg_write;
  logic        cfg_sel;
  logic [1:0]  cfg_channel;
  logic [15:0] cfg_data;
  logic        run;
  logic        step;
  logic        step_clear;
  logic        output_active;
  logic [3:0]  invert;
  logic [3:0]  step_index;
  logic        cycle_done;
  logic [7:0]  driver_io;
  logic        busy;
  logic [3:0]  step_index3;
  logic        cycle_done3;
  logic [5:0]  driver_io3;
  logic        busy3;

  int compare_count;
  int fail_count;
  int overlap_count;
  int dead_viol;
  int zero_run [4];
  logic had_drive [4];
  logic [1:0] last_pair [4];

  driver_array_core dut (
    .clock(clock), .reset(reset), .cfg_write(cfg_write), .cfg_sel(cfg_sel),
    .cfg_channel(cfg_channel), .cfg_data(cfg_data), .run(run), .step(step),
    .step_clear(step_clear), .output_active(output_active), .invert(invert),
    .step_index(step_index), .cycle_done(cycle_done), .driver_io(driver_io), .busy(busy)
  );

  driver_array_core #(.NUM_CHANNELS(3)) dut3 (
    .clock(clock), .reset(reset), .cfg_write(cfg_write), .cfg_sel(cfg_sel),
    .cfg_channel(cfg_channel), .cfg_data(cfg_data), .run(run), .step(step),
    .step_clear(step_clear), .output_active(output_active), .invert(invert[2:0]),
    .step_index(step_index3), .cycle_done(cycle_done3), .driver_io(driver_io3), .busy(busy3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watches every channel for p/n overlap and for drive-to-drive gaps shorter than the dead time.
  always @(negedge clock) begin
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        zero_run[c]  = 0;
        had_drive[c] = 1'b0;
        last_pair[c] = 2'b00;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        logic [1:0] pair;
        pair = driver_io[2*c +: 2];
        if (pair == 2'b11) overlap_count++;
        if (pair != 2'b00) begin
          if (had_drive[c] && (((zero_run[c] == 0) && (pair != last_pair[c])) ||
                               ((zero_run[c] > 0) && (zero_run[c] < 3))))
            dead_viol++;
          had_drive[c] = 1'b1;
          last_pair[c] = pair;
          zero_run[c]  = 0;
        end else if (had_drive[c]) begin
          zero_run[c]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] ch, input logic [15:0] data);
    cfg_write   = 1'b1;
    cfg_sel     = sel;
    cfg_channel = ch;
    cfg_data    = data;
    tick();
    cfg_write   = 1'b0;
  endtask

  initial begin
    compare_count = 0;
    fail_count    = 0;
    overlap_count = 0;
    dead_viol     = 0;
    reset         = 1'b1;
    cfg_write     = 1'b0;
    cfg_sel       = 1'b0;
    cfg_channel   = 2'd0;
    cfg_data      = 16'h0000;
    run           = 1'b0;
    step          = 1'b0;
    step_clear    = 1'b0;
    output_active = 1'b0;
    invert        = 4'b0000;

    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rst_io", 32'(driver_io), 32'h0);
    checkOutput("rst_idx", 32'(step_index), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(cycle_done), 32'h0);
    checkOutput("rst_io3", 32'(driver_io3), 32'h0);
    checkOutput("rst_idx3", 32'(step_index3), 32'h0);
    checkOutput("rst_done3", 32'(cycle_done3), 32'h0);

    // Basic drive on channel 0, then a polarity change through dead time.
    output_active = 1'b1;
    run           = 1'b1;
    applyStimulus(1'b0, 2'd0, 16'h0001);
    applyStimulus(1'b1, 2'd0, 16'hFFFF);
    checkOutput("basic_latency", 32'(driver_io), 32'h0);
    tick();
    checkOutput("basic_drive_p", 32'(driver_io), 32'h02);
    checkOutput("basic_busy0", 32'(busy), 32'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    checkOutput("basic_idx1", 32'(step_index), 32'h1);
    checkOutput("basic_step_lat", 32'(driver_io), 32'h02);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("basic_dead_io", 32'(driver_io), 32'h0);
      checkOutput("basic_dead_busy", 32'(busy), 32'h1);
    end
    tick();
    checkOutput("basic_drive_n", 32'(driver_io), 32'h01);
    checkOutput("basic_busy_end", 32'(busy), 32'h0);
    applyStimulus(1'b1, 2'd0, 16'h0000);
    repeat (5) tick();
    checkOutput("basic_idle_io", 32'(driver_io), 32'h0);
    checkOutput("basic_idle_busy", 32'(busy), 32'h0);
    step_clear = 1'b1;
    tick();
    step_clear = 1'b0;
    checkOutput("clear_idx", 32'(step_index), 32'h0);

    // Inverted channel 2, config write coinciding with a step, then output gating.
    invert = 4'b0100;
    step   = 1'b1;
    tick();
    applyStimulus(1'b1, 2'd2, 16'h0004);
    step = 1'b0;
    checkOutput("inv_idx2", 32'(step_index), 32'h2);
    checkOutput("inv_latency", 32'(driver_io), 32'h0);
    tick();
    checkOutput("inv_drive", 32'(driver_io), 32'h20);
    step = 1'b1;
    tick();
    step = 1'b0;
    checkOutput("inv_idx3", 32'(step_index), 32'h3);
    checkOutput("inv_hold", 32'(driver_io), 32'h20);
    tick();
    checkOutput("inv_dead_io", 32'(driver_io), 32'h0);
    checkOutput("inv_dead_busy", 32'(busy), 32'h1);
    repeat (3) tick();
    checkOutput("inv_idle_busy", 32'(busy), 32'h0);
    applyStimulus(1'b1, 2'd2, 16'hFFFF);
    tick();
    checkOutput("gate_drive", 32'(driver_io), 32'h20);
    output_active = 1'b0;
    tick();
    checkOutput("gate_dead_io", 32'(driver_io), 32'h0);
    checkOutput("gate_dead_busy", 32'(busy), 32'h1);
    repeat (2) tick();
    checkOutput("gate_dead3_busy", 32'(busy), 32'h1);
    tick();
    checkOutput("gate_idle_busy", 32'(busy), 32'h0);
    checkOutput("gate_idle_io", 32'(driver_io), 32'h0);
    applyStimulus(1'b1, 2'd2, 16'h0000);
    invert        = 4'b0000;
    output_active = 1'b1;
    step_clear    = 1'b1;
    tick();
    step_clear = 1'b0;

    // Index wrap with a single cycle_done pulse, run gating, and step_clear priority.
    step = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput("wrap_idx", 32'(step_index), 32'(i % 16));
      checkOutput("wrap_done", 32'(cycle_done), 32'(i == 16));
    end
    step = 1'b0;
    tick();
    checkOutput("wrap_done_clr", 32'(cycle_done), 32'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    checkOutput("step_idx1", 32'(step_index), 32'h1);
    run  = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    checkOutput("norun_idx", 32'(step_index), 32'h1);
    run  = 1'b1;
    step = 1'b1;
    repeat (14) tick();
    step = 1'b0;
    checkOutput("idx15", 32'(step_index), 32'hF);
    step_clear = 1'b1;
    step       = 1'b1;
    tick();
    step_clear = 1'b0;
    step       = 1'b0;
    checkOutput("clr_prio_idx", 32'(step_index), 32'h0);
    checkOutput("clr_prio_done", 32'(cycle_done), 32'h0);

    // Polarity toggled every cycle on channel 1; settles on p once the word stops changing.
    applyStimulus(1'b1, 2'd1, 16'hFFFF);
    for (int k = 1; k <= 12; k++)
      applyStimulus(1'b0, 2'd1, (k % 2 == 1) ? 16'hFFFF : 16'h0000);
    applyStimulus(1'b0, 2'd1, 16'hFFFF);
    repeat (8) tick();
    checkOutput("toggle_settle", 32'(driver_io), 32'h08);
    applyStimulus(1'b1, 2'd1, 16'h0000);
    repeat (5) tick();
    checkOutput("toggle_idle", 32'(driver_io), 32'h0);

    // Channel 3 exists only on the 4-channel instance.
    applyStimulus(1'b1, 2'd3, 16'hFFFF);
    tick();
    checkOutput("oor_io3", 32'(driver_io3), 32'h0);
    checkOutput("oor_busy3", 32'(busy3), 32'h0);
    checkOutput("ch3_drive", 32'(driver_io), 32'h40);
    applyStimulus(1'b0, 2'd3, 16'hFFFF);
    applyStimulus(1'b1, 2'd3, 16'h0000);
    applyStimulus(1'b0, 2'd3, 16'h0000);
    repeat (5) tick();
    checkOutput("oor_after_io3", 32'(driver_io3), 32'h0);
    checkOutput("ch3_idle", 32'(driver_io), 32'h0);

    // Asynchronous reset while channel 0 sits in dead time.
    applyStimulus(1'b1, 2'd0, 16'hFFFF);
    tick();
    checkOutput("ar_drive", 32'(driver_io), 32'h02);
    applyStimulus(1'b1, 2'd0, 16'h0000);
    tick();
    checkOutput("ar_dead_busy", 32'(busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_busy_now", 32'(busy), 32'h0);
    checkOutput("ar_io_now", 32'(driver_io), 32'h0);
    tick();
    reset = 1'b0;
    checkOutput("ar_idx", 32'(step_index), 32'h0);
    tick();
    checkOutput("ar_idle_io", 32'(driver_io), 32'h0);
    applyStimulus(1'b1, 2'd0, 16'hFFFF);
    tick();
    checkOutput("ar_state_cleared", 32'(driver_io), 32'h01);

    checkOutput("no_overlap", 32'(overlap_count), 32'h0);
    checkOutput("dead_gap", 32'(dead_viol), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
